// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Bridges single-cycle MemRead/MemWrite control to a valid/ready
//            variable-latency data memory, stalling the core until completion.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] MemDataOut,
    output logic                  Stall,
    output logic                  Err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_err;

    logic w_op;
    logic w_issue;
    logic w_load_cap;
    logic w_timeout;

    assign w_op = MemRead | MemWrite;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_load_cap  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_op) begin
                    w_state_nxt = S_REQ;
                    w_issue     = 1'b1;
                end
            end
            S_REQ: begin
                // Only a store accepted now completes; a read accepted on the
                // last counted cycle has no time left for its response.
                if (mem_req_ready && r_we) begin
                    w_state_nxt = S_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_DONE;
                    w_timeout   = 1'b1;
                end else if (mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    w_state_nxt = S_DONE;
                    w_load_cap  = 1'b1;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_DONE;
                    w_timeout   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_data_out <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= (w_issue & MemRead & MemWrite) | w_timeout;
            if (w_issue) begin
                r_cnt   <= '0;
                r_we    <= MemWrite;
                r_addr  <= Addr;
                r_wdata <= WriteData;
            end else if (r_state == S_REQ || r_state == S_WAIT) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            if (w_load_cap) begin
                r_data_out <= mem_rsp_rdata;
            end else if (w_timeout && !r_we) begin
                r_data_out <= '0;
            end
        end
    end

    assign Stall         = ((r_state == S_IDLE) && w_op) || (r_state == S_REQ) || (r_state == S_WAIT);
    assign mem_req_valid = (r_state == S_REQ);
    assign mem_req_we    = r_we;
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;
    assign MemDataOut    = r_data_out;
    assign Err           = r_err;

endmodule

`default_nettype wire
